// File: rtl/md_pkg.sv
// Shared constants and types for the EX-stage multiply/divide issue controller.
package md_pkg;

    localparam int MD_LAT = 5;

    localparam logic [5:0] F_MFHI  = 6'h10;
    localparam logic [5:0] F_MTHI  = 6'h11;
    localparam logic [5:0] F_MFLO  = 6'h12;
    localparam logic [5:0] F_MTLO  = 6'h13;
    localparam logic [5:0] F_MULT  = 6'h18;
    localparam logic [5:0] F_MULTU = 6'h19;
    localparam logic [5:0] F_DIV   = 6'h1A;
    localparam logic [5:0] F_DIVU  = 6'h1B;

    localparam logic [1:0] MD_MULTU = 2'd0;
    localparam logic [1:0] MD_MULT  = 2'd1;
    localparam logic [1:0] MD_DIVU  = 2'd2;
    localparam logic [1:0] MD_DIV   = 2'd3;

    typedef logic [1:0] md_state_t;
    localparam md_state_t ST_IDLE   = 2'd0;
    localparam md_state_t ST_ISSUED = 2'd1;
    localparam md_state_t ST_RUN    = 2'd2;

endpackage

// File: rtl/md_decode.sv
// Combinational decode of SPECIAL-opcode funct codes that target the mul/div unit.
module md_decode
    import md_pkg::*;
(
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    output logic       is_md,
    output logic       is_muldiv,
    output logic       is_mt,
    output logic       is_mf,
    output logic [1:0] op,
    output logic       hilo
);

    // funct[1] clear selects HI for both the move-to and move-from pairs
    assign hilo = ~funct[1];

    // Classify the instruction and pick the unit opcode
    always_comb begin
        is_md     = 1'b0;
        is_muldiv = 1'b0;
        is_mt     = 1'b0;
        is_mf     = 1'b0;
        op        = MD_MULTU;
        if (opcode == 6'h00) begin
            case (funct)
                F_MULT:  begin is_md = 1'b1; is_muldiv = 1'b1; op = MD_MULT;  end
                F_MULTU: begin is_md = 1'b1; is_muldiv = 1'b1; op = MD_MULTU; end
                F_DIV:   begin is_md = 1'b1; is_muldiv = 1'b1; op = MD_DIV;   end
                F_DIVU:  begin is_md = 1'b1; is_muldiv = 1'b1; op = MD_DIVU;  end
                F_MTHI, F_MTLO: begin is_md = 1'b1; is_mt = 1'b1; end
                F_MFHI, F_MFLO: begin is_md = 1'b1; is_mf = 1'b1; end
                default: begin is_md = 1'b0; end
            endcase
        end else begin
            is_md = 1'b0;
        end
    end

endmodule

// File: rtl/md_issue_ctrl.sv
// EX-stage issue/hazard controller for the multiply/divide unit: launch, stall,
// mfhi/mflo result register, sticky error flags and a stall-cycle counter.
module md_issue_ctrl #(
    parameter int MD_LAT = md_pkg::MD_LAT
) (
    input  logic        Clk,
    input  logic        Rst,
    input  logic [31:0] Instr_E,
    input  logic        Valid_E,
    input  logic        Flush,
    input  logic [31:0] RsData,
    input  logic [31:0] RtData,
    input  logic        Busy,
    input  logic [31:0] HI,
    input  logic [31:0] LO,
    output logic [31:0] D1,
    output logic [31:0] D2,
    output logic [1:0]  Op,
    output logic        Start,
    output logic        We,
    output logic        HiLo,
    output logic        Stall,
    output logic [31:0] MdOut,
    output logic        MdOutValid,
    output logic        DivZero,
    output logic        MdTimeout,
    output logic [31:0] StallCnt
);
    import md_pkg::*;

    localparam logic [7:0] WD_LAST = 8'(MD_LAT + 2);

    logic        is_md_s, is_muldiv_s, is_mt_s, is_mf_s, hilo_s;
    logic [1:0]  op_s;
    logic        md_class_s, tracking_s, wdog_hit_s, unused_bits_s;
    md_state_t   state_r, state_nxt_s;
    logic [7:0]  wdog_r, wdog_nxt_s;

    md_decode u_decode (
        .opcode    (Instr_E[31:26]),
        .funct     (Instr_E[5:0]),
        .is_md     (is_md_s),
        .is_muldiv (is_muldiv_s),
        .is_mt     (is_mt_s),
        .is_mf     (is_mf_s),
        .op        (op_s),
        .hilo      (hilo_s)
    );

    assign unused_bits_s = ^Instr_E[25:6];

    assign md_class_s = is_md_s & Valid_E & ~Flush;
    assign Stall      = md_class_s & (Busy | (state_r == ST_ISSUED));
    assign Start      = md_class_s & is_muldiv_s & ~Stall;
    assign We         = md_class_s & is_mt_s & ~Stall;
    assign Op         = op_s;
    assign HiLo       = hilo_s;
    assign D1         = RsData;
    assign D2         = RtData;

    // The watchdog fires on the last permitted tracking cycle, i.e. MD_LAT+3 non-idle cycles
    assign tracking_s = (state_r != ST_IDLE);
    assign wdog_hit_s = tracking_s & (wdog_r == WD_LAST);

    // Next-state and watchdog logic; a new launch restarts tracking from ISSUED
    always_comb begin
        state_nxt_s = state_r;
        wdog_nxt_s  = wdog_r;
        if (Start) begin
            state_nxt_s = ST_ISSUED;
            wdog_nxt_s  = 8'd0;
        end else if (wdog_hit_s) begin
            state_nxt_s = ST_IDLE;
            wdog_nxt_s  = 8'd0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    state_nxt_s = ST_IDLE;
                    wdog_nxt_s  = 8'd0;
                end
                ST_ISSUED: begin
                    wdog_nxt_s  = wdog_r + 8'd1;
                    state_nxt_s = Busy ? ST_RUN : ST_ISSUED;
                end
                ST_RUN: begin
                    if (Busy) begin
                        state_nxt_s = ST_RUN;
                        wdog_nxt_s  = wdog_r + 8'd1;
                    end else begin
                        state_nxt_s = ST_IDLE;
                        wdog_nxt_s  = 8'd0;
                    end
                end
                default: begin
                    state_nxt_s = ST_IDLE;
                    wdog_nxt_s  = 8'd0;
                end
            endcase
        end
    end

    // FSM state, watchdog and sticky flags
    always_ff @(posedge Clk) begin
        if (Rst) begin
            state_r   <= ST_IDLE;
            wdog_r    <= 8'd0;
            DivZero   <= 1'b0;
            MdTimeout <= 1'b0;
            StallCnt  <= 32'd0;
        end else begin
            state_r <= state_nxt_s;
            wdog_r  <= wdog_nxt_s;
            if (wdog_hit_s) begin
                MdTimeout <= 1'b1;
            end
            if (Start && op_s[1] && (RtData == 32'd0)) begin
                DivZero <= 1'b1;
            end
            if (Stall) begin
                StallCnt <= StallCnt + 32'd1;
            end
        end
    end

    // mfhi/mflo result register for the EX/MEM boundary
    always_ff @(posedge Clk) begin
        if (Rst) begin
            MdOut      <= 32'd0;
            MdOutValid <= 1'b0;
        end else if (md_class_s && is_mf_s && !Stall) begin
            MdOut      <= hilo_s ? HI : LO;
            MdOutValid <= 1'b1;
        end else begin
            MdOutValid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_md_issue_ctrl.sv
// Scoreboard bench for md_issue_ctrl with a behavioural mul/div unit and reference model.
module tb_md_issue_ctrl;

    localparam int LAT = 5;

    logic        Clk = 1'b0;
    logic        Rst = 1'b1;
    logic [31:0] Instr_E = 32'd0;
    logic        Valid_E = 1'b0;
    logic        Flush = 1'b0;
    logic [31:0] RsData = 32'd0;
    logic [31:0] RtData = 32'd0;
    logic        Busy = 1'b0;
    logic [31:0] HI = 32'd0;
    logic [31:0] LO = 32'd0;
    logic [31:0] D1, D2, MdOut, StallCnt;
    logic [1:0]  Op;
    logic        Start, We, HiLo, Stall, MdOutValid, DivZero, MdTimeout;

    md_issue_ctrl #(.MD_LAT(LAT)) dut (
        .Clk(Clk), .Rst(Rst), .Instr_E(Instr_E), .Valid_E(Valid_E), .Flush(Flush),
        .RsData(RsData), .RtData(RtData), .Busy(Busy), .HI(HI), .LO(LO),
        .D1(D1), .D2(D2), .Op(Op), .Start(Start), .We(We), .HiLo(HiLo), .Stall(Stall),
        .MdOut(MdOut), .MdOutValid(MdOutValid), .DivZero(DivZero), .MdTimeout(MdTimeout),
        .StallCnt(StallCnt)
    );

    always #5 Clk = ~Clk;

    int compared = 0;
    int mismatched = 0;
    logic [31:0] exp_q[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [63:0] compute(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        logic signed [63:0] sp;
        logic signed [31:0] sa, sb;
        sa = a;
        sb = b;
        case (op)
            2'd1: begin
                sp = 64'(sa) * 64'(sb);
                return sp;
            end
            2'd0: return {32'd0, a} * {32'd0, b};
            2'd2: return (b == 32'd0) ? {a, 32'hFFFFFFFF} : {a % b, a / b};
            default: begin
                if (b == 32'd0) return {a, 32'hFFFFFFFF};
                if (a == 32'h80000000 && b == 32'hFFFFFFFF) return {32'd0, a};
                return {32'(sa % sb), 32'(sa / sb)};
            end
        endcase
    endfunction

    // Behavioural mul/div unit: busy LAT cycles after a launch, results land as Busy falls
    logic        force_busy = 1'b0;
    logic [31:0] res_hi = 32'd0, res_lo = 32'd0;
    int          cnt = 0;
    always @(posedge Clk) begin
        if (force_busy) begin
            Busy <= 1'b1;
            cnt  <= 0;
        end else if (Start) begin
            Busy <= 1'b1;
            cnt  <= LAT - 1;
            {res_hi, res_lo} <= compute(Op, D1, D2);
        end else if (Busy) begin
            if (cnt == 0) begin
                Busy <= 1'b0;
                HI   <= res_hi;
                LO   <= res_lo;
            end else begin
                cnt <= cnt - 1;
            end
        end
        if (We) begin
            if (HiLo) HI <= D1;
            else      LO <= D1;
        end
    end

    // 0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mfhi, 6 mthi, 7 mflo, 8 mtlo
    function automatic int kind_of(input logic [31:0] ins);
        if (ins[31:26] != 6'h00) return 0;
        case (ins[5:0])
            6'h18: return 1;
            6'h19: return 2;
            6'h1A: return 3;
            6'h1B: return 4;
            6'h10: return 5;
            6'h11: return 6;
            6'h12: return 7;
            6'h13: return 8;
            default: return 0;
        endcase
    endfunction

    function automatic logic [31:0] rinst(input logic [5:0] f);
        return {6'h00, 20'h0, f};
    endfunction

    // Reference model: an operation is "outstanding" from launch until the unit has been
    // seen busy and then idle, or until it has been tracked for LAT+3 cycles.
    bit          outstanding = 0, seen = 0;
    int          age = 0;
    bit          m_divzero = 0, m_timeout = 0;
    logic [31:0] m_stallcnt = 32'd0;

    task automatic step(input logic [31:0] ins, input logic v, input logic fl,
                        input logic [31:0] rs, input logic [31:0] rt, input logic rst,
                        output bit stalled);
        int k;
        bit mdc, e_stall, e_start, e_we, busy_s;
        logic [1:0] e_op;
        Instr_E = ins; Valid_E = v; Flush = fl; RsData = rs; RtData = rt; Rst = rst;
        @(negedge Clk);
        busy_s  = Busy;
        k       = kind_of(ins);
        mdc     = (k != 0) && v && !fl;
        e_stall = mdc && (busy_s || (outstanding && !seen));
        e_start = mdc && (k >= 1 && k <= 4) && !e_stall;
        e_we    = mdc && (k == 6 || k == 8) && !e_stall;
        chk("stall", 32'(Stall), 32'(e_stall));
        chk("start", 32'(Start), 32'(e_start));
        chk("we", 32'(We), 32'(e_we));
        if (e_start) begin
            e_op = (k == 1) ? 2'd1 : (k == 2) ? 2'd0 : (k == 3) ? 2'd3 : 2'd2;
            chk("op", 32'(Op), 32'(e_op));
            chk("d1", D1, rs);
            chk("d2", D2, rt);
        end
        if (e_we) chk("hilo", 32'(HiLo), (k == 6) ? 32'd1 : 32'd0);
        if (mdc && (k == 5 || k == 7) && !e_stall && !rst) exp_q.push_back((k == 5) ? HI : LO);
        stalled = e_stall;
        @(posedge Clk);
        if (rst) begin
            outstanding = 0; seen = 0; age = 0;
            m_divzero = 0; m_timeout = 0; m_stallcnt = 32'd0;
        end else begin
            if (e_stall) m_stallcnt = m_stallcnt + 32'd1;
            if (e_start && (k == 3 || k == 4) && rt == 32'd0) m_divzero = 1;
            if (outstanding) begin
                age++;
                if (age == LAT + 3) begin
                    m_timeout = 1; outstanding = 0;
                end else if (seen && !busy_s) begin
                    outstanding = 0;
                end else if (busy_s) begin
                    seen = 1;
                end
            end
            if (e_start) begin
                outstanding = 1; seen = 0; age = 0;
            end
        end
        #1;
        chk("divzero", 32'(DivZero), 32'(m_divzero));
        chk("timeout", 32'(MdTimeout), 32'(m_timeout));
        chk("stallcnt", StallCnt, m_stallcnt);
    endtask

    // Monitor: every fresh MdOut must match the oldest pending expectation
    always @(negedge Clk) begin
        if (MdOutValid) begin
            if (exp_q.size() == 0) begin
                compared++;
                mismatched++;
                $display("FAIL mdout_unexpected: got %h expected no result", MdOut);
            end else begin
                chk("mdout", MdOut, exp_q.pop_front());
            end
        end
    end

    task automatic issue_until_free(input string name, input logic [31:0] ins,
                                    input logic [31:0] rs, input logic [31:0] rt);
        bit st;
        st = 1;
        for (int i = 0; i < 30 && st; i++) step(ins, 1'b1, 1'b0, rs, rt, 1'b0, st);
        chk(name, 32'(st), 32'd0);
    endtask

    task automatic idle(input int n);
        bit st;
        for (int i = 0; i < n; i++) step(32'd0, 1'b0, 1'b0, 32'd0, 32'd0, 1'b0, st);
    endtask

    initial begin
        bit st;
        logic [31:0] cur, rs, rt;
        logic v, fl, r;
        step(32'd0, 1'b0, 1'b0, 32'd0, 32'd0, 1'b1, st);
        step(32'd0, 1'b0, 1'b0, 32'd0, 32'd0, 1'b1, st);
        chk("rst_mdout", MdOut, 32'd0);
        chk("rst_valid", 32'(MdOutValid), 32'd0);
        idle(2);

        // 1: mult 3 * -2, mflo waits for the unit
        step(rinst(6'h18), 1'b1, 1'b0, 32'd3, 32'hFFFFFFFE, 1'b0, st);
        issue_until_free("t1_issue", rinst(6'h12), 32'd0, 32'd0);
        chk("t1_mdout", MdOut, 32'hFFFFFFFA);
        chk("t1_valid", 32'(MdOutValid), 32'd1);

        // 2: divu back-to-back with multu, then mfhi
        step(rinst(6'h1B), 1'b1, 1'b0, 32'd7, 32'd2, 1'b0, st);
        issue_until_free("t2_multu", rinst(6'h19), 32'h80000000, 32'd4);
        issue_until_free("t2_mfhi", rinst(6'h10), 32'd0, 32'd0);
        chk("t2_mdout", MdOut, 32'd2);

        // 3: mthi then mfhi without a stall
        step(rinst(6'h11), 1'b1, 1'b0, 32'h0000DEAD, 32'd0, 1'b0, st);
        step(rinst(6'h10), 1'b1, 1'b0, 32'd0, 32'd0, 1'b0, st);
        chk("t3_nostall", 32'(st), 32'd0);
        chk("t3_mdout", MdOut, 32'h0000DEAD);

        // 4: divide by zero, flushed div while busy
        step(rinst(6'h1A), 1'b1, 1'b0, 32'd5, 32'd0, 1'b0, st);
        chk("t4_divzero", 32'(DivZero), 32'd1);
        step(rinst(6'h1A), 1'b1, 1'b1, 32'd5, 32'd3, 1'b0, st);
        idle(8);
        step(rinst(6'h1A), 1'b1, 1'b1, 32'd5, 32'd0, 1'b0, st);

        // 5: unit stuck busy trips the watchdog
        step(rinst(6'h18), 1'b1, 1'b0, 32'd2, 32'd3, 1'b0, st);
        force_busy = 1'b1;
        for (int i = 0; i < 20; i++) step(rinst(6'h12), 1'b1, 1'b0, 32'd0, 32'd0, 1'b0, st);
        chk("t5_timeout", 32'(MdTimeout), 32'd1);
        force_busy = 1'b0;
        issue_until_free("t5_mflo", rinst(6'h12), 32'd0, 32'd0);

        // 6: reset while the unit is running
        step(rinst(6'h18), 1'b1, 1'b0, 32'd9, 32'd9, 1'b0, st);
        idle(2);
        step(32'd0, 1'b0, 1'b0, 32'd0, 32'd0, 1'b1, st);
        chk("t6_stallcnt", StallCnt, 32'd0);
        chk("t6_timeout", 32'(MdTimeout), 32'd0);
        issue_until_free("t6_mflo", rinst(6'h12), 32'd0, 32'd0);

        // Randomized traffic; a stalled instruction usually stays in EX
        cur = 32'd0; rs = 32'd0; rt = 32'd0; v = 1'b0; st = 0;
        for (int n = 0; n < 600; n++) begin
            if (!(st && $urandom_range(0, 3) != 0)) begin
                case ($urandom_range(0, 9))
                    0: cur = rinst(6'h18);
                    1: cur = rinst(6'h19);
                    2: cur = rinst(6'h1A);
                    3: cur = rinst(6'h1B);
                    4: cur = rinst(6'h10);
                    5: cur = rinst(6'h11);
                    6: cur = rinst(6'h12);
                    7: cur = rinst(6'h13);
                    8: cur = {6'h00, 20'($urandom), 6'h20};
                    default: cur = {6'($urandom_range(1, 63)), 20'($urandom), 6'h18};
                endcase
                rs = $urandom();
                rt = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom();
                v  = ($urandom_range(0, 7) != 0);
            end
            fl = ($urandom_range(0, 7) == 0);
            r  = ($urandom_range(0, 79) == 0);
            step(cur, v, fl, rs, rt, r, st);
        end

        idle(12);
        chk("drain", exp_q.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
